// File: rtl/riscv_alu_arb.sv
// -----------------------------------------------------------------------------
// riscv_alu_arb
//
// Shares one ALU and its ALU-control decoder between two requesters: the
// execute stage (requester 0) and the load/store address-generation unit
// (requester 1). Each cycle at most one request is granted. The winner's
// opcode, funct3, funct7 and operands are steered onto the shared ALU inputs.
// The ALU result is registered and returned to the winner one cycle later.
//
// Ports
//   clk_i, rst_i              core clock; synchronous active-high reset
//   flush_i                   suppresses the response pulse due next cycle
//   reqN_valid_i              request pending (N = 0, 1)
//   reqN_opcode_i/funct3_i/funct7_i/a_i/b_i   request fields, held until granted
//   reqN_ready_o              grant; combinational from the valids and last_q
//   alu_opcode_o/funct3_o/funct7_o/a_o/b_o    shared ALU inputs (0 when idle)
//   alu_result_i              combinational ALU result for the alu_* outputs
//   rspN_valid_o              one-cycle response pulse for requester N
//   rsp_data_o                registered ALU result
//
// Configuration
//   ALU_ARB_FIXED_PRI_EN      when defined, requester 0 always wins a tie and
//                             the round-robin pointer is removed. Requester 1
//                             can starve in this mode. When undefined
//                             (default), round-robin arbitration is used.
// -----------------------------------------------------------------------------
module riscv_alu_arb #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,

    input  logic            req0_valid_i,
    input  logic [6:0]      req0_opcode_i,
    input  logic [2:0]      req0_funct3_i,
    input  logic [6:0]      req0_funct7_i,
    input  logic [XLEN-1:0] req0_a_i,
    input  logic [XLEN-1:0] req0_b_i,
    output logic            req0_ready_o,

    input  logic            req1_valid_i,
    input  logic [6:0]      req1_opcode_i,
    input  logic [2:0]      req1_funct3_i,
    input  logic [6:0]      req1_funct7_i,
    input  logic [XLEN-1:0] req1_a_i,
    input  logic [XLEN-1:0] req1_b_i,
    output logic            req1_ready_o,

    output logic [6:0]      alu_opcode_o,
    output logic [2:0]      alu_funct3_o,
    output logic [6:0]      alu_funct7_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    input  logic [XLEN-1:0] alu_result_i,

    output logic            rsp0_valid_o,
    output logic            rsp1_valid_o,
    output logic [XLEN-1:0] rsp_data_o
);

    logic grant0;
    logic grant1;

`ifdef ALU_ARB_FIXED_PRI_EN
    // Fixed priority: requester 0 wins whenever it asks.
    assign grant0 = req0_valid_i;
`else
    // Index of the most recent winner. On a tie, the other requester wins.
    logic last_q;

    assign grant0 = req0_valid_i && (!req1_valid_i || last_q);
`endif

    // Requester 1 takes the slot whenever requester 0 does not. This keeps the
    // grants one-hot and means the grants never depend on alu_result_i.
    assign grant1 = req1_valid_i && !grant0;

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Drive the shared ALU from the winner. An idle cycle presents opcode 0,
    // which ALU-control decodes as a nop.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        alu_opcode_o = '0;
        alu_funct3_o = '0;
        alu_funct7_o = '0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        if (grant0) begin
            alu_opcode_o = req0_opcode_i;
            alu_funct3_o = req0_funct3_i;
            alu_funct7_o = req0_funct7_i;
            alu_a_o      = req0_a_i;
            alu_b_o      = req0_b_i;
        end else if (grant1) begin
            alu_opcode_o = req1_opcode_i;
            alu_funct3_o = req1_funct3_i;
            alu_funct7_o = req1_funct7_i;
            alu_a_o      = req1_a_i;
            alu_b_o      = req1_b_i;
        end
    end

    // Response register. Reset dominates flush and any transfer in the same
    // cycle. A flush only suppresses the pulse. The data is still captured,
    // and the pointer still advances.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples values from before the edge.
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            rsp_data_o   <= '0;
`ifndef ALU_ARB_FIXED_PRI_EN
            last_q       <= 1'b1;   // requester 0 wins the first tie
`endif
        end else begin
            rsp0_valid_o <= grant0 && !flush_i;
            rsp1_valid_o <= grant1 && !flush_i;
            if (grant0 || grant1) begin
                rsp_data_o <= alu_result_i;
`ifndef ALU_ARB_FIXED_PRI_EN
                last_q     <= grant1;
`endif
            end
        end
    end

endmodule
